alu_md: RTL and testbench
=========================

// Module: alu_md
// PURPOSE
//  Parametrised multi-cycle ALU; successor to the 16-bit combinational ALU.
//  Adds shifts, iterative multiply (shift-add) and divide (restoring), a remainder/high-word output,
//  and valid/ready handshakes on input and output. Sits between the decode/issue stage and writeback of the CPU datapath.
// PARAMETERS
//  WIDTH   16   operand/result width in bits (>=4, power of two)
//  OP_W     4   opcode width (fixed encoding below)
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-high reset
//  in_valid   in   1      operands/op present
//  in_ready   out  1      unit can accept (state==IDLE), combinational from state
//  op         in   OP_W   operation code
//  a, b       in   WIDTH  operands
//  out_valid  out  1      result registers hold a completed result
//  out_ready  in   1      consumer takes result
//  result     out  WIDTH  main result (low product / quotient)
//  hi         out  WIDTH  high product / remainder; 0 for non-MD ops
//  zero       out  1      result==0 (registered with result)
//  dz         out  1      divide-by-zero occurred on this result
// BEHAVIOUR
//  - Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0110 SUB, 0111 SLT (signed, result 1/0),
//    1000 SLL, 1001 SRL, 1010 SRA (amount = b[$clog2(WIDTH)-1:0]), 1100 MULU, 1101 DIVU; others -> result 0, hi 0.
//  - ADD/SUB wrap modulo 2^WIDTH, no flags beyond zero.
//  - FSM: IDLE -> (accept, simple op or div-by-zero) -> DONE; IDLE -> (accept, MD op) -> BUSY;
//    BUSY -> DONE after WIDTH iterations; DONE -> IDLE when out_ready.
//  - Accept = in_valid & in_ready on edge E. Operands latched at E; later changes on a/b/op are ignored.
//  - Latency: simple ops and div-by-zero: out_valid=1 after edge E+1. MULU/DIVU: out_valid=1 after edge E+WIDTH+1.
//  - out_valid stays 1 and result/hi/zero/dz hold stable until out_ready sampled 1; out_valid drops next cycle.
//  - in_ready=0 in BUSY and DONE (no overlap; accept resumes cycle after handoff).
//  - DIVU b==0: result all ones, hi=a, dz=1, 1-cycle path. dz=0 for every other result.
//  - Reset (any state, incl. mid-BUSY): state IDLE, out_valid 0, result 0, hi 0, zero 0, dz 0; in-flight op discarded.
//  - Reset dominates in_valid in the same cycle.
// CONFIGURATION
//  ALU_MD_SIGNED_EN defined: adds 1110 MUL (signed, 2W product in {hi,result}) and 1111 DIV (signed,
//    quotient truncates toward zero, remainder takes dividend sign). Magnitudes iterated, sign fix in final
//    cycle; same latency as unsigned. DIV MIN/-1 -> result MIN, hi 0. DIV by 0 same as DIVU.
//  Not defined: 1110/1111 behave as unused opcodes (result 0, hi 0, simple-op latency).
// TESTING (WIDTH=16)
//  1 ADD a=7FFF b=0001 -> result 8000, hi 0, zero 0, out_valid 1 cycle after accept; SUB 1234-1234 -> 0, zero 1.
//  2 SLT a=FFFF b=0001 -> 0001; SRA a=8000 b=0013 (amt 3) -> F000; SLL a=0001 b=000F -> 8000.
//  3 MULU a=1234 b=0100 -> hi 0012 result 3400, out_valid exactly 17 cycles after accept, in_ready 0 throughout.
//  4 DIVU 0064/0007 -> result 000E hi 0002 dz 0; DIVU 0005/0000 -> result FFFF hi 0005 dz 1 after 1 cycle.
//  5 out_ready held 0 for 3 cycles after out_valid -> outputs stable, in_ready 0; in_valid ignored until handoff.
//  6 reset asserted 5 cycles into MULU -> next cycle out_valid 0, in_ready 1, no result emitted;
//    with ALU_MD_SIGNED_EN: MUL FFFE*0003 -> hi FFFF result FFFA; DIV FFF9/0002 -> result FFFD hi FFFF.

Source files
------------

// File: rtl/alu_md.sv
// alu_md: multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle logic/arith/shift ops, shift-add multiply and restoring divide
// (WIDTH iterations each), remainder/high-word output on hi.
// Optional feature macro: ALU_MD_SIGNED_EN adds signed MUL (1110) and DIV (1111).
//
// state | meaning
// IDLE  | ready to accept an operation
// EXEC  | single-cycle op (incl. divide-by-zero) computed into result regs
// BUSY  | WIDTH multiply/divide iterations, then one sign-fix/writeback cycle
// DONE  | result held until out_ready
module alu_md #(
  parameter int WIDTH = 16,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             dz
);
  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [OP_W-1:0] OP_AND  = OP_W'(4'h0);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(4'h1);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(4'h2);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(4'h3);
  localparam logic [OP_W-1:0] OP_NOR  = OP_W'(4'h4);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(4'h6);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(4'h7);
  localparam logic [OP_W-1:0] OP_SLL  = OP_W'(4'h8);
  localparam logic [OP_W-1:0] OP_SRL  = OP_W'(4'h9);
  localparam logic [OP_W-1:0] OP_SRA  = OP_W'(4'hA);
  localparam logic [OP_W-1:0] OP_MULU = OP_W'(4'hC);
  localparam logic [OP_W-1:0] OP_DIVU = OP_W'(4'hD);
`ifdef ALU_MD_SIGNED_EN
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(4'hE);
  localparam logic [OP_W-1:0] OP_DIV  = OP_W'(4'hF);
`endif

  typedef enum logic [1:0] {IDLE, EXEC, BUSY, DONE} state_t;
  state_t state, state_d;

  logic [OP_W-1:0]  op_q;
  logic [WIDTH-1:0] a_q, b_q, acc_hi, acc_lo, opd;
  logic [CNT_W-1:0] cnt;
  logic             neg_p, neg_r;
  logic             accept, start_md;
  logic [WIDTH-1:0] mag_a, mag_b, ex_res, ex_hi, fin_lo, fin_hi;
  logic             sgn_p, sgn_r, ex_dz;
  logic [WIDTH:0]   mul_sum, div_shift, div_trial;

  function automatic logic is_div(input logic [OP_W-1:0] o);
`ifdef ALU_MD_SIGNED_EN
    return (o == OP_DIVU) || (o == OP_DIV);
`else
    return o == OP_DIVU;
`endif
  endfunction

  function automatic logic is_md(input logic [OP_W-1:0] o);
`ifdef ALU_MD_SIGNED_EN
    return (o == OP_MULU) || (o == OP_MUL) || is_div(o);
`else
    return (o == OP_MULU) || is_div(o);
`endif
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  // divide by zero takes the single-cycle path
  assign start_md  = is_md(op) && !(is_div(op) && (b == '0));

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = start_md ? BUSY : EXEC;
      EXEC:    state_d = DONE;
      BUSY:    if (cnt == '0) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // operand magnitudes and sign-fix flags for the iterative engine
  always_comb begin
    mag_a = a;
    mag_b = b;
    sgn_p = 1'b0;
    sgn_r = 1'b0;
`ifdef ALU_MD_SIGNED_EN
    if ((op == OP_MUL) || (op == OP_DIV)) begin
      if (a[WIDTH-1]) mag_a = -a;
      if (b[WIDTH-1]) mag_b = -b;
      sgn_p = a[WIDTH-1] ^ b[WIDTH-1];
      sgn_r = (op == OP_DIV) && a[WIDTH-1];
    end
`endif
  end

  // single-cycle results from latched operands
  always_comb begin
    ex_res = '0;
    ex_hi  = '0;
    ex_dz  = 1'b0;
    case (op_q)
      OP_AND:  ex_res = a_q & b_q;
      OP_OR:   ex_res = a_q | b_q;
      OP_ADD:  ex_res = a_q + b_q;
      OP_XOR:  ex_res = a_q ^ b_q;
      OP_NOR:  ex_res = ~(a_q | b_q);
      OP_SUB:  ex_res = a_q - b_q;
      OP_SLT:  ex_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SLL:  ex_res = a_q << b_q[SH_W-1:0];
      OP_SRL:  ex_res = a_q >> b_q[SH_W-1:0];
      OP_SRA:  ex_res = $signed(a_q) >>> b_q[SH_W-1:0];
      default: begin
        // only a zero-divisor divide reaches EXEC with a divide opcode
        if (is_div(op_q)) begin
          ex_res = '1;
          ex_hi  = a_q;
          ex_dz  = 1'b1;
        end
      end
    endcase
  end

  // one shift-add / restoring-divide step
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_trial = div_shift - {1'b0, opd};
  end

  // final sign correction of the magnitude result
  always_comb begin
    fin_lo = acc_lo;
    fin_hi = acc_hi;
    if (is_div(op_q)) begin
      if (neg_p) fin_lo = -acc_lo;
      if (neg_r) fin_hi = -acc_hi;
    end else if (neg_p) begin
      {fin_hi, fin_lo} = -{acc_hi, acc_lo};
    end
  end

  // operand capture, iteration engine and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opd    <= '0;
      cnt    <= '0;
      neg_p  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
      hi     <= '0;
      zero   <= 1'b0;
      dz     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q   <= op;
          a_q    <= a;
          b_q    <= b;
          cnt    <= CNT_W'(WIDTH);
          acc_hi <= '0;
          acc_lo <= is_div(op) ? mag_a : mag_b;
          opd    <= is_div(op) ? mag_b : mag_a;
          neg_p  <= sgn_p;
          neg_r  <= sgn_r;
        end
        EXEC: begin
          result <= ex_res;
          hi     <= ex_hi;
          zero   <= (ex_res == '0);
          dz     <= ex_dz;
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
            if (is_div(op_q)) begin
              if (!div_trial[WIDTH]) begin
                acc_hi <= div_trial[WIDTH-1:0];
                acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
              end else begin
                acc_hi <= div_shift[WIDTH-1:0];
                acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
              end
            end else begin
              acc_hi <= mul_sum[WIDTH:1];
              acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
          end else begin
            result <= fin_lo;
            hi     <= fin_hi;
            zero   <= (fin_lo == '0);
            dz     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_md.sv
// Testbench for alu_md (WIDTH=16): directed vectors, handshake/hold,
// reset behaviour and randomized ops against a behavioural model.
module tb_alu_md;
  localparam int W  = 16;
  localparam int NV = 10;
  localparam int TO = 40;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, out_valid, out_ready, zero, dz;
  logic [3:0]   op;
  logic [W-1:0] a, b, result, hi;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_md #(.WIDTH(W), .OP_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .hi(hi), .zero(zero), .dz(dz)
  );

  logic [3:0]  dv_op [NV] = '{4'h2, 4'h6, 4'h7, 4'hA, 4'h8, 4'h9, 4'hC, 4'hD, 4'hD, 4'h5};
  logic [15:0] dv_a  [NV] = '{16'h7FFF, 16'h1234, 16'hFFFF, 16'h8000, 16'h0001,
                              16'h8000, 16'h1234, 16'h0064, 16'h0005, 16'h1234};
  logic [15:0] dv_b  [NV] = '{16'h0001, 16'h1234, 16'h0001, 16'h0013, 16'h000F,
                              16'h0004, 16'h0100, 16'h0007, 16'h0000, 16'h5678};
  logic [15:0] dv_r  [NV] = '{16'h8000, 16'h0000, 16'h0001, 16'hF000, 16'h8000,
                              16'h0800, 16'h3400, 16'h000E, 16'hFFFF, 16'h0000};
  logic [15:0] dv_h  [NV] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                              16'h0000, 16'h0012, 16'h0002, 16'h0005, 16'h0000};
  logic        dv_d  [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  int          dv_lat[NV] = '{1, 1, 1, 1, 1, 1, 17, 17, 1, 1};

  // reference: plain arithmetic on the operation definitions
  function automatic void model(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                                output logic [15:0] r, output logic [15:0] h,
                                output logic d, output int lat);
    int          sx, sy;
    logic [31:0] up;
    sx = int'($signed(x));
    sy = int'($signed(y));
    r = 16'h0; h = 16'h0; d = 1'b0; lat = 1;
    case (o)
      4'h0: r = x & y;
      4'h1: r = x | y;
      4'h2: r = x + y;
      4'h3: r = x ^ y;
      4'h4: r = ~(x | y);
      4'h6: r = x - y;
      4'h7: r = (sx < sy) ? 16'd1 : 16'd0;
      4'h8: r = x << y[3:0];
      4'h9: r = x >> y[3:0];
      4'hA: r = 16'(sx >>> y[3:0]);
      4'hC: begin up = 32'(x) * 32'(y); r = up[15:0]; h = up[31:16]; lat = 17; end
      4'hD: begin
        if (y == 16'h0) begin r = 16'hFFFF; h = x; d = 1'b1; end
        else begin r = x / y; h = x % y; lat = 17; end
      end
`ifdef ALU_MD_SIGNED_EN
      4'hE: begin up = 32'(sx * sy); r = up[15:0]; h = up[31:16]; lat = 17; end
      4'hF: begin
        if (y == 16'h0) begin r = 16'hFFFF; h = x; d = 1'b1; end
        else begin r = 16'(sx / sy); h = 16'(sx % sy); lat = 17; end
      end
`endif
      default: ;
    endcase
  endfunction

  // drive one op; keeps in_valid high with garbage while the unit is busy
  task automatic issue(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                       output int lat, output bit rdy_seen);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    lat = 0; rdy_seen = 1'b0;
    while (!out_valid && lat < TO) begin
      if (in_ready) rdy_seen = 1'b1;
      op = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handoff();
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 4'h0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_tests++; if ({result, hi} !== 32'h0) begin n_fail++; $display("FAIL reset_result_hi: got %h/%h want 0/0", result, hi); end
    n_tests++; if ({zero, dz} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got zero=%b dz=%b want 0 0", zero, dz); end
    // reset held together with a valid request: request must be dropped
    in_valid = 1'b1; op = 4'h2; a = 16'h0001; b = 16'h0001;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_dominates: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_directed();
    int lat; bit rs; logic ez;
    for (int i = 0; i < NV; i++) begin
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL dir%0d_ready: got %b want 1", i, in_ready); end
      issue(dv_op[i], dv_a[i], dv_b[i], lat, rs);
      ez = (dv_r[i] == 16'h0);
      n_tests++; if (lat != dv_lat[i]) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, dv_lat[i]); end
      n_tests++; if (rs !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL dir%0d_busy_ready: got seen=%b now=%b want 0 0", i, rs, in_ready); end
      n_tests++; if (result !== dv_r[i]) begin n_fail++; $display("FAIL dir%0d_result: got %h want %h", i, result, dv_r[i]); end
      n_tests++; if (hi !== dv_h[i]) begin n_fail++; $display("FAIL dir%0d_hi: got %h want %h", i, hi, dv_h[i]); end
      n_tests++; if (zero !== ez) begin n_fail++; $display("FAIL dir%0d_zero: got %b want %b", i, zero, ez); end
      n_tests++; if (dz !== dv_d[i]) begin n_fail++; $display("FAIL dir%0d_dz: got %b want %b", i, dz, dv_d[i]); end
      handoff();
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL dir%0d_handoff: got out_valid=%b in_ready=%b want 0 1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_hold();
    logic [3:0] ops [2] = '{4'h2, 4'hC};
    logic [15:0] x, y, er, eh; logic ed; int el, lat; bit rs;
    for (int k = 0; k < 2; k++) begin
      x = 16'($urandom); y = 16'($urandom);
      model(ops[k], x, y, er, eh, ed, el);
      issue(ops[k], x, y, lat, rs);
      n_tests++; if (lat != el) begin n_fail++; $display("FAIL hold%0d_latency: got %0d want %0d", k, lat, el); end
      for (int c = 0; c < 3; c++) begin
        op = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
        @(posedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== er || hi !== eh || dz !== ed) begin
          n_fail++;
          $display("FAIL hold%0d_cyc%0d: got v=%b rdy=%b r=%h h=%h dz=%b want 1 0 %h %h %b",
                   k, c, out_valid, in_ready, result, hi, dz, er, eh, ed);
        end
      end
      handoff();
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL hold%0d_handoff: got out_valid=%b in_ready=%b want 0 1", k, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_reset_busy();
    int seen;
    in_valid = 1'b1; op = 4'hC; a = 16'h1234; b = 16'h0100;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstbusy_state: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    n_tests++;
    if ({result, hi, zero, dz} !== 34'h0) begin
      n_fail++; $display("FAIL rstbusy_regs: got r=%h h=%h z=%b dz=%b want 0", result, hi, zero, dz);
    end
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL rstbusy_no_emit: got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_random();
    logic [3:0] o; logic [15:0] x, y, er, eh; logic ed; int el, lat, hold; bit rs;
    for (int i = 0; i < 150; i++) begin
      o = 4'($urandom_range(0, 15));
      x = 16'($urandom);
      y = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      model(o, x, y, er, eh, ed, el);
      hold = $urandom_range(0, 2);
      issue(o, x, y, lat, rs);
      repeat (hold) begin @(posedge clk); #1; end
      n_tests++;
      if (lat != el || rs !== 1'b0) begin
        n_fail++; $display("FAIL rand%0d_timing op=%h: got lat=%0d seen_ready=%b want %0d 0", i, o, lat, rs, el);
      end
      n_tests++;
      if (result !== er || hi !== eh || zero !== (er == 16'h0) || dz !== ed) begin
        n_fail++;
        $display("FAIL rand%0d_value op=%h a=%h b=%h: got r=%h h=%h z=%b dz=%b want %h %h %b %b",
                 i, o, x, y, result, hi, zero, dz, er, eh, (er == 16'h0), ed);
      end
      handoff();
    end
  endtask

`ifdef ALU_MD_SIGNED_EN
  task automatic test_signed();
    logic [3:0]  so [4] = '{4'hE, 4'hF, 4'hF, 4'hF};
    logic [15:0] sa [4] = '{16'hFFFE, 16'hFFF9, 16'h8000, 16'h1234};
    logic [15:0] sb [4] = '{16'h0003, 16'h0002, 16'hFFFF, 16'h0000};
    logic [15:0] sr [4] = '{16'hFFFA, 16'hFFFD, 16'h8000, 16'hFFFF};
    logic [15:0] sh [4] = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h1234};
    logic        sd [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int          sl [4] = '{17, 17, 17, 1};
    int lat; bit rs;
    for (int i = 0; i < 4; i++) begin
      issue(so[i], sa[i], sb[i], lat, rs);
      n_tests++; if (lat != sl[i]) begin n_fail++; $display("FAIL sgn%0d_latency: got %0d want %0d", i, lat, sl[i]); end
      n_tests++;
      if (result !== sr[i] || hi !== sh[i] || dz !== sd[i]) begin
        n_fail++; $display("FAIL sgn%0d_value: got r=%h h=%h dz=%b want %h %h %b", i, result, hi, dz, sr[i], sh[i], sd[i]);
      end
      handoff();
    end
  endtask
`else
  task automatic test_unused_ext();
    logic [3:0] uo [2] = '{4'hE, 4'hF};
    int lat; bit rs;
    for (int i = 0; i < 2; i++) begin
      issue(uo[i], 16'hFFFE, 16'h0003, lat, rs);
      n_tests++;
      if (lat != 1 || result !== 16'h0 || hi !== 16'h0 || dz !== 1'b0 || zero !== 1'b1) begin
        n_fail++; $display("FAIL unused%0d: got lat=%0d r=%h h=%h dz=%b z=%b want 1 0000 0000 0 1", i, lat, result, hi, dz, zero);
      end
      handoff();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_busy();
`ifdef ALU_MD_SIGNED_EN
    test_signed();
`else
    test_unused_ext();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
